// File: rtl/cache_arbiter.sv
// Cacheline arbiter: one LLC adaptor port shared by I-cache (read) and D-cache (read/write).
// Latency: request sampled in IDLE at t -> adaptor strobe at t+1; adaptor resp forwarded same cycle.
// Backpressure: caches hold requests until their resp; the loser waits, round-robin on ties.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   i_address_i/i_read_i    : I-cache line request; i_line_o/i_resp_o return the line
//   d_address_i/d_read_i/d_write_i/d_line_i : D-cache line request and writeback data
//   d_line_o/d_resp_o       : D-cache read data and completion pulse
//   mem_*                   : adaptor port (address, read/write strobes, lines, resp)
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  // I-cache
  input  logic [ADDR_W-1:0] i_address_i,
  input  logic              i_read_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  // D-cache
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  // Cacheline adaptor
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [LINE_W-1:0] mem_line_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp_i
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT_I  = 3'd1,
    GRANT_DR = 3'd2,
    GRANT_DW = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;       // latched grant address; zero outside grants
  logic                r_last_d;     // 1 = D-cache was served last
  logic                r_mem_read;
  logic                r_mem_write;

  logic w_req_i;
  logic w_req_d;
  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;

  assign w_req_i   = i_read_i;
  assign w_req_d   = d_read_i | d_write_i;
  // D wins when it is alone, or on a tie when I was served last.
  assign w_pick_d  = w_req_d & (~w_req_i | ~r_last_d);
  assign w_grant_i = (r_state == GRANT_I);
  assign w_grant_d = (r_state == GRANT_DR) | (r_state == GRANT_DW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_last_d    <= 1'b1;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_i || w_req_d) begin
            r_last_d <= w_pick_d;
            if (w_pick_d) begin
              r_addr <= d_address_i;
              // Read+write together is illegal; write wins so only one strobe is ever raised.
              if (d_write_i) begin
                r_state     <= GRANT_DW;
                r_mem_write <= 1'b1;
              end else begin
                r_state    <= GRANT_DR;
                r_mem_read <= 1'b1;
              end
            end else begin
              r_addr     <= i_address_i;
              r_state    <= GRANT_I;
              r_mem_read <= 1'b1;
            end
          end
        end
        GRANT_I, GRANT_DR, GRANT_DW: begin
          // Strobes and address are held from registers only, so a requester
          // changing its inputs mid-transaction cannot disturb the adaptor.
          if (mem_resp_i) begin
            r_state     <= RELEASE;
            r_addr      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        RELEASE: begin
          // One dead cycle lets requesters drop their request and the adaptor idle.
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_addr      <= '0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address_o = r_addr;
  assign mem_read_o    = r_mem_read;
  assign mem_write_o   = r_mem_write;
  assign mem_line_o    = d_line_i;

  // Response is routed combinationally to the current owner only; resp in
  // IDLE/RELEASE is dropped.
  assign i_resp_o = mem_resp_i & w_grant_i;
  assign d_resp_o = mem_resp_i & w_grant_d;
  assign i_line_o = mem_line_i;
  assign d_line_o = mem_line_i;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin reference model.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] i_address_i;
  logic              i_read_i;
  logic [LINE_W-1:0] i_line_o;
  logic              i_resp_o;
  logic [ADDR_W-1:0] d_address_i;
  logic              d_read_i;
  logic              d_write_i;
  logic [LINE_W-1:0] d_line_i;
  logic [LINE_W-1:0] d_line_o;
  logic              d_resp_o;
  logic [ADDR_W-1:0] mem_address_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_line_o;
  logic [LINE_W-1:0] mem_line_i;
  logic              mem_resp_i;

  int n_cmp = 0;
  int n_bad = 0;
  // Reference model state: who was served last (1 = D-cache).
  bit m_last_d;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_address_i(i_address_i), .i_read_i(i_read_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
    .d_address_i(d_address_i), .d_read_i(d_read_i), .d_write_i(d_write_i), .d_line_i(d_line_i),
    .d_line_o(d_line_o), .d_resp_o(d_resp_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int j = 0; j < LINE_W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0; mem_resp_i = 1'b0;
    i_address_i = '0; d_address_i = '0; d_line_i = '0; mem_line_i = '0;
    repeat (2) cyc();
    mem_resp_i = 1'b1; i_read_i = 1'b1; d_write_i = 1'b1;
    settle();
    n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got=%b want=00", {mem_read_o, mem_write_o}); end
    n_cmp++; if (mem_address_o !== '0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", mem_address_o); end
    n_cmp++; if ({i_resp_o, d_resp_o} !== 2'b00) begin n_bad++; $display("FAIL reset_resp got=%b want=00", {i_resp_o, d_resp_o}); end
    mem_resp_i = 1'b0; i_read_i = 1'b0; d_write_i = 1'b0;
    reset_n = 1'b1;
    m_last_d = 1'b1;
    cyc();
  endtask

  task automatic test_i_read();
    logic [LINE_W-1:0] a5;
    a5 = {(LINE_W / 8){8'hA5}};
    i_address_i = 32'h0000_1000; i_read_i = 1'b1;
    settle();
    n_cmp++; if (mem_read_o !== 1'b0) begin n_bad++; $display("FAIL ird_early got=%b want=0", mem_read_o); end
    cyc();
    n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b10) begin n_bad++; $display("FAIL ird_strobe got=%b want=10", {mem_read_o, mem_write_o}); end
    n_cmp++; if (mem_address_o !== 32'h0000_1000) begin n_bad++; $display("FAIL ird_addr got=%h want=1000", mem_address_o); end
    repeat (7) begin
      cyc();
      n_cmp++; if ({mem_read_o, i_resp_o, d_resp_o} !== 3'b100) begin n_bad++; $display("FAIL ird_hold got=%b want=100", {mem_read_o, i_resp_o, d_resp_o}); end
    end
    mem_line_i = a5; mem_resp_i = 1'b1;
    settle();
    n_cmp++; if ({i_resp_o, d_resp_o} !== 2'b10) begin n_bad++; $display("FAIL ird_resp got=%b want=10", {i_resp_o, d_resp_o}); end
    n_cmp++; if (i_line_o !== a5) begin n_bad++; $display("FAIL ird_line got=%h want=%h", i_line_o, a5); end
    cyc();
    mem_resp_i = 1'b0; i_read_i = 1'b0;
    settle();
    n_cmp++; if ({mem_read_o, i_resp_o} !== 2'b00) begin n_bad++; $display("FAIL ird_release got=%b want=00", {mem_read_o, i_resp_o}); end
    cyc();
    m_last_d = 1'b0;
  endtask

  task automatic test_d_write();
    logic [LINE_W-1:0] p;
    int resp_cnt;
    p = rand_line();
    resp_cnt = 0;
    d_address_i = 32'h0000_2000; d_line_i = p; d_write_i = 1'b1;
    cyc();
    for (int c = 0; c < 5; c++) begin
      if (c == 4) mem_resp_i = 1'b1;
      settle();
      n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b01) begin n_bad++; $display("FAIL dwr_strobe c=%0d got=%b want=01", c, {mem_read_o, mem_write_o}); end
      n_cmp++; if (mem_line_o !== p) begin n_bad++; $display("FAIL dwr_line got=%h want=%h", mem_line_o, p); end
      if (d_resp_o === 1'b1) resp_cnt++;
      cyc();
    end
    mem_resp_i = 1'b0; d_write_i = 1'b0;
    settle();
    if (d_resp_o === 1'b1) resp_cnt++;
    n_cmp++; if (resp_cnt !== 1) begin n_bad++; $display("FAIL dwr_resp_count got=%0d want=1", resp_cnt); end
    n_cmp++; if (mem_address_o !== '0) begin n_bad++; $display("FAIL dwr_release_addr got=%h want=0", mem_address_o); end
    cyc();
    m_last_d = 1'b1;
  endtask

  task automatic test_back_to_back();
    int gap;
    bit exp_d;
    logic [ADDR_W-1:0] exp_a;
    reset_n = 1'b0; #1; reset_n = 1'b1;
    m_last_d = 1'b1;
    i_address_i = 32'h0000_0100; d_address_i = 32'h0000_0200;
    i_read_i = 1'b1; d_read_i = 1'b1; d_write_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      exp_d = !m_last_d;
      m_last_d = exp_d;
      exp_a = exp_d ? d_address_i : i_address_i;
      cyc();
      mem_resp_i = 1'b0;
      gap = 0;
      while (!(mem_read_o || mem_write_o) && gap < 8) begin gap++; cyc(); end
      n_cmp++; if (gap !== (g == 0 ? 0 : 2)) begin n_bad++; $display("FAIL b2b_gap g=%0d got=%0d want=%0d", g, gap, (g == 0 ? 0 : 2)); end
      n_cmp++; if ({mem_read_o, mem_address_o} !== {1'b1, exp_a}) begin n_bad++; $display("FAIL b2b_grant g=%0d got=%b/%h want=1/%h", g, mem_read_o, mem_address_o, exp_a); end
      repeat ($urandom_range(0, 3)) cyc();
      mem_resp_i = 1'b1;
      settle();
      n_cmp++; if ({i_resp_o, d_resp_o} !== {!exp_d, exp_d}) begin n_bad++; $display("FAIL b2b_resp g=%0d got=%b want=%b", g, {i_resp_o, d_resp_o}, {!exp_d, exp_d}); end
    end
    cyc();
    mem_resp_i = 1'b0; i_read_i = 1'b0; d_read_i = 1'b0;
    cyc();
  endtask

  task automatic test_illegal_rw();
    d_address_i = 32'h0000_3000; d_read_i = 1'b1; d_write_i = 1'b1;
    cyc();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_resp_i = 1'b1;
      settle();
      n_cmp++; if ({mem_read_o, mem_write_o, mem_address_o} !== {2'b01, 32'h0000_3000}) begin n_bad++; $display("FAIL rw_only_write c=%0d got=%b/%h want=01/3000", c, {mem_read_o, mem_write_o}, mem_address_o); end
      cyc();
    end
    mem_resp_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
    cyc();
    m_last_d = 1'b1;
  endtask

  task automatic test_spurious();
    mem_resp_i = 1'b1;
    settle();
    n_cmp++; if ({i_resp_o, d_resp_o} !== 2'b00) begin n_bad++; $display("FAIL spur_idle_resp got=%b want=00", {i_resp_o, d_resp_o}); end
    cyc();
    mem_resp_i = 1'b0;
    settle();
    n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b00) begin n_bad++; $display("FAIL spur_idle_strobe got=%b want=00", {mem_read_o, mem_write_o}); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] ia;
    d_address_i = $urandom; d_read_i = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (mem_read_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got=%b want=1", mem_read_o); end
    #1 reset_n = 1'b0; mem_resp_i = 1'b1;
    #1;
    n_cmp++; if ({mem_read_o, mem_write_o, d_resp_o, i_resp_o} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_out got=%b want=0000", {mem_read_o, mem_write_o, d_resp_o, i_resp_o}); end
    n_cmp++; if (mem_address_o !== '0) begin n_bad++; $display("FAIL rstmid_addr got=%h want=0", mem_address_o); end
    reset_n = 1'b1; mem_resp_i = 1'b0;
    m_last_d = 1'b1;
    ia = $urandom;
    i_address_i = ia; i_read_i = 1'b1;
    cyc();
    n_cmp++; if ({mem_read_o, mem_address_o} !== {1'b1, ia}) begin n_bad++; $display("FAIL rstmid_tie got=%b/%h want=1/%h", mem_read_o, mem_address_o, ia); end
    m_last_d = 1'b0;
    mem_resp_i = 1'b1;
    settle();
    n_cmp++; if ({i_resp_o, d_resp_o} !== 2'b10) begin n_bad++; $display("FAIL rstmid_resp got=%b want=10", {i_resp_o, d_resp_o}); end
    cyc();
    mem_resp_i = 1'b0; i_read_i = 1'b0; d_read_i = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    bit ri, rd, rw, win_d, exp_w;
    int lat;
    logic [ADDR_W-1:0] ia, da, exp_a;
    logic [LINE_W-1:0] dl, ml;
    for (int k = 0; k < 40; k++) begin
      ri = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      if (!(ri || rd || rw)) ri = 1'b1;
      lat = $urandom_range(0, 4);
      ia = $urandom; da = $urandom; dl = rand_line(); ml = rand_line();
      // Model: D wins if alone or if I was served last; write beats read.
      win_d = (rd || rw) && (!ri || !m_last_d);
      m_last_d = win_d;
      exp_w = win_d && rw;
      exp_a = win_d ? da : ia;
      i_address_i = ia; d_address_i = da; d_line_i = dl;
      i_read_i = ri; d_read_i = rd; d_write_i = rw;
      settle();
      n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b00) begin n_bad++; $display("FAIL rnd_idle k=%0d got=%b want=00", k, {mem_read_o, mem_write_o}); end
      cyc();
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) begin
          cyc();
          i_address_i = $urandom; d_address_i = $urandom;
          settle();
        end
        n_cmp++; if ({mem_read_o, mem_write_o} !== {!exp_w, exp_w}) begin n_bad++; $display("FAIL rnd_strobe k=%0d c=%0d got=%b want=%b", k, c, {mem_read_o, mem_write_o}, {!exp_w, exp_w}); end
        n_cmp++; if (mem_address_o !== exp_a) begin n_bad++; $display("FAIL rnd_addr k=%0d c=%0d got=%h want=%h", k, c, mem_address_o, exp_a); end
      end
      if (exp_w) begin
        n_cmp++; if (mem_line_o !== dl) begin n_bad++; $display("FAIL rnd_wline k=%0d got=%h want=%h", k, mem_line_o, dl); end
      end
      mem_line_i = ml; mem_resp_i = 1'b1;
      settle();
      n_cmp++; if ({i_resp_o, d_resp_o} !== {!win_d, win_d}) begin n_bad++; $display("FAIL rnd_resp k=%0d got=%b want=%b", k, {i_resp_o, d_resp_o}, {!win_d, win_d}); end
      n_cmp++; if ((win_d ? d_line_o : i_line_o) !== ml) begin n_bad++; $display("FAIL rnd_rline k=%0d got=%h want=%h", k, (win_d ? d_line_o : i_line_o), ml); end
      cyc();
      mem_resp_i = 1'($urandom_range(0, 1)); i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
      settle();
      n_cmp++; if ({mem_read_o, mem_write_o, i_resp_o, d_resp_o} !== 4'b0000) begin n_bad++; $display("FAIL rnd_release k=%0d got=%b want=0000", k, {mem_read_o, mem_write_o, i_resp_o, d_resp_o}); end
      cyc();
      mem_resp_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_back_to_back();
    test_illegal_rw();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
